// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue controller between the two decoder ways and EX.
// Tracks long-latency destinations in a 32-entry scoreboard, resolves
// RAW/WAW/intra-bundle/structural hazards and grants one or both ways.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_i             abandon the current bundle
//   wayN_*_i            decoded instruction fields for way0 (older) / way1
//   exReady_i           EX accepts issue this cycle
//   wbValid_i/wbAddr_i  long-latency writeback clearing the scoreboard
//   ready_o             combinational: bundle fully consumed
//   wayN_issue_o/pID_o  registered issue strobes and packet IDs
//   busy_o              scoreboard
//   stallCnt_o          saturating stall-cycle counter
module dual_issue_scheduler #(
  parameter int unsigned STALL_CNT_W = 16,
  parameter int unsigned LONG_PORTS  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   way0_valid_i,
  input  logic                   way1_valid_i,
  input  logic [1:0]             way0_pID_i,
  input  logic [1:0]             way1_pID_i,
  input  logic [4:0]             way0_rs1Addr_i,
  input  logic [4:0]             way0_rs2Addr_i,
  input  logic [4:0]             way1_rs1Addr_i,
  input  logic [4:0]             way1_rs2Addr_i,
  input  logic                   way0_rs1ReadEnable_i,
  input  logic                   way0_rs2ReadEnable_i,
  input  logic                   way1_rs1ReadEnable_i,
  input  logic                   way1_rs2ReadEnable_i,
  input  logic [4:0]             way0_rdAddr_i,
  input  logic [4:0]             way1_rdAddr_i,
  input  logic                   way0_rdWriteEnable_i,
  input  logic                   way1_rdWriteEnable_i,
  input  logic                   way0_longLat_i,
  input  logic                   way1_longLat_i,
  input  logic                   exReady_i,
  input  logic                   wbValid_i,
  input  logic [4:0]             wbAddr_i,
  output logic                   ready_o,
  output logic                   way0_issue_o,
  output logic                   way1_issue_o,
  output logic [1:0]             way0_pID_o,
  output logic [1:0]             way1_pID_o,
  output logic [31:0]            busy_o,
  output logic [STALL_CNT_W-1:0] stallCnt_o
);

  localparam int unsigned REG_N = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic {BUNDLE, HOLD1} state_t;

  state_t            state, state_next;
  logic              grant0, grant1, stall_c;
  logic              src_haz0, src_haz1, waw_haz0, waw_haz1;
  logic              intra_haz, struct_haz, ok0, ok1;
  logic [REG_N-1:0]  set_mask, clr_mask, busy_next;

  // Source hazard with same-cycle writeback bypass; x0 never hazards.
  function automatic logic src_haz(input logic en, input logic [REG_W-1:0] a,
                                   input logic [REG_N-1:0] busy, input logic wbv,
                                   input logic [REG_W-1:0] wba);
    return en && (a != '0) && busy[a] && !(wbv && (wba == a));
  endfunction

  assign src_haz0 = src_haz(way0_rs1ReadEnable_i, way0_rs1Addr_i, busy_o, wbValid_i, wbAddr_i) ||
                    src_haz(way0_rs2ReadEnable_i, way0_rs2Addr_i, busy_o, wbValid_i, wbAddr_i);
  assign src_haz1 = src_haz(way1_rs1ReadEnable_i, way1_rs1Addr_i, busy_o, wbValid_i, wbAddr_i) ||
                    src_haz(way1_rs2ReadEnable_i, way1_rs2Addr_i, busy_o, wbValid_i, wbAddr_i);
  assign waw_haz0 = way0_rdWriteEnable_i && busy_o[way0_rdAddr_i];
  assign waw_haz1 = way1_rdWriteEnable_i && busy_o[way1_rdAddr_i];

  // way1 depends on (or overwrites) way0's destination inside the bundle.
  assign intra_haz = way0_rdWriteEnable_i && (way0_rdAddr_i != '0) &&
                     ((way1_rs1ReadEnable_i && (way1_rs1Addr_i == way0_rdAddr_i)) ||
                      (way1_rs2ReadEnable_i && (way1_rs2Addr_i == way0_rdAddr_i)) ||
                      (way1_rdWriteEnable_i && (way1_rdAddr_i  == way0_rdAddr_i)));
  assign struct_haz = (LONG_PORTS == 1) && way0_longLat_i && way1_longLat_i;

  assign ok0 = way0_valid_i && !src_haz0 && !waw_haz0 && exReady_i;
  assign ok1 = way1_valid_i && !src_haz1 && !waw_haz1 && exReady_i;

  // Next state, grants and ready.
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    ready_o    = 1'b0;
    if (flush_i) begin
      state_next = BUNDLE;
    end else begin
      case (state)
        BUNDLE: begin
          if (ok0) begin
            grant0 = 1'b1;
            if (!way1_valid_i || (ok1 && !intra_haz && !struct_haz)) begin
              grant1  = way1_valid_i;
              ready_o = 1'b1;
            end else begin
              state_next = HOLD1;
            end
          end
        end
        HOLD1: begin
          if (!way1_valid_i) begin
            ready_o    = 1'b1;
            state_next = BUNDLE;
          end else if (ok1) begin
            grant1     = 1'b1;
            ready_o    = 1'b1;
            state_next = BUNDLE;
          end
        end
        default: state_next = BUNDLE;
      endcase
    end
    stall_c = !flush_i &&
              (((state == BUNDLE) && way0_valid_i && !grant0) ||
               ((state == HOLD1)  && way1_valid_i && !grant1));
  end

  // Scoreboard update: set beats clear on the same register.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (grant0 && way0_rdWriteEnable_i && way0_longLat_i && (way0_rdAddr_i != '0))
      set_mask[way0_rdAddr_i] = 1'b1;
    if (grant1 && way1_rdWriteEnable_i && way1_longLat_i && (way1_rdAddr_i != '0))
      set_mask[way1_rdAddr_i] = 1'b1;
    if (wbValid_i)
      clr_mask[wbAddr_i] = 1'b1;
    busy_next = (busy_o & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BUNDLE;
      busy_o       <= '0;
      way0_issue_o <= 1'b0;
      way1_issue_o <= 1'b0;
      way0_pID_o   <= '0;
      way1_pID_o   <= '0;
      stallCnt_o   <= '0;
    end else begin
      state        <= state_next;
      busy_o       <= busy_next;
      way0_issue_o <= grant0;
      way1_issue_o <= grant1;
      way0_pID_o   <= grant0 ? way0_pID_i : 2'b00;
      way1_pID_o   <= grant1 ? way1_pID_i : 2'b00;
      if (stall_c && (stallCnt_o != '1))
        stallCnt_o <= stallCnt_o + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: one DUT with a single long-latency
// port and one with two, driven by the same inputs.
module tb_dual_issue_scheduler;

  localparam int unsigned SW = 4;

  logic clk = 1'b0;
  logic rst, flush;
  logic w0v, w1v;
  logic [1:0] w0pid, w1pid;
  logic [4:0] w0rs1, w0rs2, w1rs1, w1rs2, w0rd, w1rd;
  logic w0rs1e, w0rs2e, w1rs1e, w1rs2e, w0we, w1we, w0ll, w1ll;
  logic exr, wbv;
  logic [4:0] wba;

  logic rdy, i0, i1, rdy_b, i0_b, i1_b;
  logic [1:0] p0, p1, p0_b, p1_b;
  logic [31:0] busy, busy_b;
  logic [SW-1:0] scnt, scnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dual_issue_scheduler #(.STALL_CNT_W(SW), .LONG_PORTS(1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .way0_valid_i(w0v), .way1_valid_i(w1v), .way0_pID_i(w0pid), .way1_pID_i(w1pid),
    .way0_rs1Addr_i(w0rs1), .way0_rs2Addr_i(w0rs2), .way1_rs1Addr_i(w1rs1), .way1_rs2Addr_i(w1rs2),
    .way0_rs1ReadEnable_i(w0rs1e), .way0_rs2ReadEnable_i(w0rs2e),
    .way1_rs1ReadEnable_i(w1rs1e), .way1_rs2ReadEnable_i(w1rs2e),
    .way0_rdAddr_i(w0rd), .way1_rdAddr_i(w1rd),
    .way0_rdWriteEnable_i(w0we), .way1_rdWriteEnable_i(w1we),
    .way0_longLat_i(w0ll), .way1_longLat_i(w1ll),
    .exReady_i(exr), .wbValid_i(wbv), .wbAddr_i(wba),
    .ready_o(rdy), .way0_issue_o(i0), .way1_issue_o(i1),
    .way0_pID_o(p0), .way1_pID_o(p1), .busy_o(busy), .stallCnt_o(scnt));

  dual_issue_scheduler #(.STALL_CNT_W(SW), .LONG_PORTS(2)) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush),
    .way0_valid_i(w0v), .way1_valid_i(w1v), .way0_pID_i(w0pid), .way1_pID_i(w1pid),
    .way0_rs1Addr_i(w0rs1), .way0_rs2Addr_i(w0rs2), .way1_rs1Addr_i(w1rs1), .way1_rs2Addr_i(w1rs2),
    .way0_rs1ReadEnable_i(w0rs1e), .way0_rs2ReadEnable_i(w0rs2e),
    .way1_rs1ReadEnable_i(w1rs1e), .way1_rs2ReadEnable_i(w1rs2e),
    .way0_rdAddr_i(w0rd), .way1_rdAddr_i(w1rd),
    .way0_rdWriteEnable_i(w0we), .way1_rdWriteEnable_i(w1we),
    .way0_longLat_i(w0ll), .way1_longLat_i(w1ll),
    .exReady_i(exr), .wbValid_i(wbv), .wbAddr_i(wba),
    .ready_o(rdy_b), .way0_issue_o(i0_b), .way1_issue_o(i1_b),
    .way0_pID_o(p0_b), .way1_pID_o(p1_b), .busy_o(busy_b), .stallCnt_o(scnt_b));

  task automatic idle_inputs();
    flush = 1'b0; exr = 1'b1; wbv = 1'b0; wba = '0;
    w0v = 1'b0; w0pid = '0; w0rs1 = '0; w0rs2 = '0; w0rs1e = 1'b0; w0rs2e = 1'b0;
    w0rd = '0; w0we = 1'b0; w0ll = 1'b0;
    w1v = 1'b0; w1pid = '0; w1rs1 = '0; w1rs2 = '0; w1rs1e = 1'b0; w1rs2e = 1'b0;
    w1rd = '0; w1we = 1'b0; w1ll = 1'b0;
  endtask

  task automatic set_w0(input logic [1:0] pid, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic ll);
    w0v = 1'b1; w0pid = pid; w0rs1 = rs1; w0rs2 = rs2; w0rs1e = 1'b1; w0rs2e = 1'b1;
    w0rd = rd; w0we = 1'b1; w0ll = ll;
  endtask

  task automatic set_w1(input logic [1:0] pid, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic ll);
    w1v = 1'b1; w1pid = pid; w1rs1 = rs1; w1rs2 = rs2; w1rs1e = 1'b1; w1rs2e = 1'b1;
    w1rd = rd; w1we = 1'b1; w1ll = ll;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; set_w0(2'd3, 5'd1, 5'd2, 5'd9, 1'b1);
    @(posedge clk); #1;
    checks++; if ({i0, i1, p0, p1} !== 6'b0) begin errors++; $display("FAIL reset_issue got=%b exp=0", {i0, i1, p0, p1}); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (scnt !== '0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", scnt); end
    @(negedge clk); rst = 1'b0; idle_inputs();
  endtask

  task automatic test_alu_pair();
    do_reset();
    @(negedge clk); set_w0(2'd1, 5'd10, 5'd11, 5'd1, 1'b0); set_w1(2'd2, 5'd12, 5'd13, 5'd2, 1'b0); #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL pair_ready got=%b exp=1", rdy); end
    @(posedge clk); #1;
    checks++; if ({i0, i1} !== 2'b11) begin errors++; $display("FAIL pair_issue got=%b exp=11", {i0, i1}); end
    checks++; if ({p0, p1} !== 4'b0110) begin errors++; $display("FAIL pair_pid got=%b exp=0110", {p0, p1}); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL pair_busy got=%h exp=0", busy); end
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    checks++; if ({i0, i1} !== 2'b00) begin errors++; $display("FAIL pair_strobe got=%b exp=00", {i0, i1}); end
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk); set_w0(2'd3, 5'd0, 5'd0, 5'd5, 1'b1); set_w1(2'd1, 5'd5, 5'd7, 5'd6, 1'b0); #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL lu_ready0 got=%b exp=0", rdy); end
    @(posedge clk); #1;
    checks++; if ({i0, i1, p0} !== 4'b1011) begin errors++; $display("FAIL lu_issue0 got=%b exp=1011", {i0, i1, p0}); end
    checks++; if (busy !== 32'h20) begin errors++; $display("FAIL lu_busy_set got=%h exp=20", busy); end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); #1;
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL lu_hold_ready got=%b exp=0", rdy); end
      @(posedge clk); #1;
      checks++; if ({i1, scnt} !== {1'b0, SW'(c)}) begin errors++; $display("FAIL lu_stall got=%b/%0d exp=0/%0d", i1, scnt, c); end
    end
    @(negedge clk); wbv = 1'b1; wba = 5'd5; #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL lu_bypass_ready got=%b exp=1", rdy); end
    @(posedge clk); #1;
    checks++; if ({i0, i1, p1} !== 4'b0101) begin errors++; $display("FAIL lu_issue1 got=%b exp=0101", {i0, i1, p1}); end
    checks++; if ({busy, scnt} !== {32'h0, SW'(2)}) begin errors++; $display("FAIL lu_busy_clr got=%h/%0d exp=0/2", busy, scnt); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_struct();
    do_reset();
    @(negedge clk); set_w0(2'd1, 5'd0, 5'd0, 5'd8, 1'b1); set_w1(2'd2, 5'd1, 5'd2, 5'd9, 1'b1); #1;
    checks++; if ({rdy, rdy_b} !== 2'b01) begin errors++; $display("FAIL st_ready got=%b exp=01", {rdy, rdy_b}); end
    @(posedge clk); #1;
    checks++; if ({i0, i1, busy} !== {2'b10, 32'h100}) begin errors++; $display("FAIL st_one_port got=%b/%h exp=10/100", {i0, i1}, busy); end
    checks++; if ({i0_b, i1_b, busy_b} !== {2'b11, 32'h300}) begin errors++; $display("FAIL st_two_port got=%b/%h exp=11/300", {i0_b, i1_b}, busy_b); end
    @(negedge clk); #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL st_ready1 got=%b exp=1", rdy); end
    @(posedge clk); #1;
    checks++; if ({i0, i1, busy} !== {2'b01, 32'h300}) begin errors++; $display("FAIL st_second got=%b/%h exp=01/300", {i0, i1}, busy); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_in_order();
    do_reset();
    @(negedge clk); set_w0(2'd0, 5'd0, 5'd0, 5'd3, 1'b1);
    @(posedge clk); #1;
    checks++; if (busy !== 32'h8) begin errors++; $display("FAIL io_busy got=%h exp=8", busy); end
    @(negedge clk); idle_inputs(); set_w0(2'd1, 5'd3, 5'd0, 5'd4, 1'b0); set_w1(2'd2, 5'd1, 5'd2, 5'd6, 1'b0); #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL io_ready got=%b exp=0", rdy); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if ({i0, i1, scnt} !== {2'b00, SW'(2)}) begin errors++; $display("FAIL io_stall got=%b/%0d exp=00/2", {i0, i1}, scnt); end
    @(negedge clk); exr = 1'b0; wbv = 1'b1; wba = 5'd3; #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL io_exready got=%b exp=0", rdy); end
    @(posedge clk); #1;
    checks++; if ({i0, busy, scnt} !== {1'b0, 32'h0, SW'(3)}) begin errors++; $display("FAIL io_exr_stall got=%b/%h/%0d exp=0/0/3", i0, busy, scnt); end
    @(negedge clk); exr = 1'b1; wbv = 1'b0;
    @(posedge clk); #1;
    checks++; if ({i0, i1} !== 2'b11) begin errors++; $display("FAIL io_release got=%b exp=11", {i0, i1}); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_flush_x0();
    do_reset();
    @(negedge clk); set_w0(2'd1, 5'd0, 5'd0, 5'd0, 1'b1); set_w1(2'd2, 5'd0, 5'd1, 5'd7, 1'b0);
    @(posedge clk); #1;
    checks++; if ({i0, i1, busy} !== {2'b11, 32'h0}) begin errors++; $display("FAIL x0_load got=%b/%h exp=11/0", {i0, i1}, busy); end
    @(negedge clk); idle_inputs(); set_w0(2'd1, 5'd0, 5'd0, 5'd10, 1'b1); set_w1(2'd2, 5'd10, 5'd1, 5'd7, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); flush = 1'b1; #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL fl_ready got=%b exp=0", rdy); end
    @(posedge clk); #1;
    checks++; if ({i0, i1, busy} !== {2'b00, 32'h400}) begin errors++; $display("FAIL fl_state got=%b/%h exp=00/400", {i0, i1}, busy); end
    @(negedge clk); idle_inputs(); set_w0(2'd2, 5'd1, 5'd2, 5'd3, 1'b0);
    @(posedge clk); #1;
    checks++; if ({i0, p0} !== 3'b110) begin errors++; $display("FAIL fl_bundle got=%b exp=110", {i0, p0}); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_saturate_reset();
    do_reset();
    @(negedge clk); set_w0(2'd1, 5'd0, 5'd0, 5'd12, 1'b1); set_w1(2'd2, 5'd12, 5'd0, 5'd13, 1'b0);
    @(posedge clk); #1;
    repeat ((1 << SW) + 3) @(posedge clk);
    #1;
    checks++; if ({scnt, busy} !== {{SW{1'b1}}, 32'h1000}) begin errors++; $display("FAIL sat_count got=%0d/%h exp=%0d/1000", scnt, busy, (1 << SW) - 1); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({i0, i1, p0, p1, busy, scnt} !== '0) begin errors++; $display("FAIL rst_mid got=%b/%h/%0d exp=0", {i0, i1, p0, p1}, busy, scnt); end
    @(negedge clk); rst = 1'b0; w0v = 1'b0; #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rst_state got=%b exp=0", rdy); end
    @(posedge clk); #1;
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alu_pair();
    test_load_use();
    test_struct();
    test_in_order();
    test_flush_x0();
    test_saturate_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
